// File: rtl/add_scheduler_pkg.sv
// Shared constants and FSM state encoding for the time-multiplexed adder scheduler.
package add_sched_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/add_scheduler_if.sv
// Operand and result handshake bundle between two requesters, one consumer and the scheduler.
interface add_scheduler_if #(parameter int W = 16);

  logic         req0_valid;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_ready;

  logic         req1_valid;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_ready;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_carry;
  logic         rsp_id;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_sum, rsp_carry, rsp_id,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_sum, rsp_carry, rsp_id,
    output rsp_ready
  );

endinterface

// File: rtl/add_scheduler_slice.sv
// Single 8-bit ripple-carry adder slice shared by every pass of the scheduler.
module adder_slice8
  import add_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               carry_in,
  output logic [SLICE_W-1:0] sum,
  output logic               carry_out
);

  logic [SLICE_W:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign carry_out = c[SLICE_W];

endmodule

// File: rtl/add_scheduler.sv
// Two-requester adder scheduler: round-robin grant, then N_SLICES passes through one
// 8-bit slice adder, then hold the result until the consumer takes it.
module add_scheduler
  import add_sched_pkg::*;
#(
  parameter int N_SLICES = 2
) (
  input  logic           clk,
  input  logic           rst,
  add_scheduler_if.slave bus
);

  localparam int W      = SLICE_W * N_SLICES;
  localparam int SIDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [SIDX_W-1:0] SLICE_LAST = SIDX_W'(N_SLICES - 1);

  state_e              state_q, state_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        sum_q, sum_d;
  logic                carry_q, carry_d;
  logic [SIDX_W-1:0]   slice_q, slice_d;
  logic                id_q, id_d;
  logic                last_q, last_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic                any_valid_s;
  logic                grant_id_s;
  logic                ready0_s;
  logic                ready1_s;
  logic [SLICE_W-1:0]  slice_sum_s;
  logic                slice_cout_s;

  // Operands shift right one slice per pass, so the active slice is always the low byte.
  adder_slice8 u_slice (
    .a         (a_q[SLICE_W-1:0]),
    .b         (b_q[SLICE_W-1:0]),
    .carry_in  (carry_q),
    .sum       (slice_sum_s),
    .carry_out (slice_cout_s)
  );

  // Round-robin grant: last_q remembers the previous winner; it resets to 1 so req0 wins first.
  always_comb begin
    any_valid_s = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_s = ~last_q;
    end else if (bus.req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    slice_d  = slice_q;
    id_d     = id_q;
    last_d   = last_q;
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready0_s = any_valid_s & ~grant_id_s;
        ready1_s = any_valid_s &  grant_id_s;
        if (any_valid_s) begin
          a_d     = grant_id_s ? bus.req1_a : bus.req0_a;
          b_d     = grant_id_s ? bus.req1_b : bus.req0_b;
          carry_d = 1'b0;
          slice_d = '0;
          id_d    = grant_id_s;
          last_d  = grant_id_s;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        a_d   = a_q >> SLICE_W;
        b_d   = b_q >> SLICE_W;
        // Result slices enter at the top; after N_SLICES passes slice 0 has reached bit 0.
        sum_d = sum_q >> SLICE_W;
        sum_d[W-1 -: SLICE_W] = slice_sum_s;
        carry_d = slice_cout_s;
        if (slice_q == SLICE_LAST) begin
          slice_d = '0;
          state_d = ST_RESP;
        end else begin
          slice_d = slice_q + 1'b1;
          state_d = ST_ADD;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      slice_q     <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      slice_q     <= slice_d;
      id_q        <= id_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_id     = id_q;

endmodule

// File: doc/add_scheduler.md
ADD_SCHEDULER -- requirements
Module: add_scheduler

Interface
REQ-001 SHALL have parameter: N_SLICES, default 2, number of 8-bit adder passes per operation; operand width W = 8*N_SLICES.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req0_valid  input  1 / req0_a  input  W / req0_b  input  W / req0_ready  output  1. These form requester 0's operand handshake.
REQ-005 SHALL have ports: req1_valid  input  1 / req1_a  input  W / req1_b  input  W / req1_ready  output  1. These form requester 1's operand handshake.
REQ-006 SHALL have ports: rsp_valid  output  1 / rsp_ready  input  1 / rsp_sum  output  W / rsp_carry  output  1 / rsp_id  output  1. These form the result handshake; rsp_id is the granted requester.

Function
REQ-007 SHALL share one 8-bit carry-chain adder between both requesters; one transaction in flight at a time.
REQ-008 SHALL implement FSM IDLE -> ADD -> RESP -> IDLE.
REQ-009 IDLE: grant SHALL be combinational; reqX_ready=1 only for the granted requester while in IDLE; both readys 0 in ADD and RESP.
REQ-010 Arbitration SHALL be round-robin: if one valid, grant it; if both valid, grant the requester not granted last; pointer after reset favours req0.
REQ-011 On reqX_valid & reqX_ready the block SHALL register a, b and id, clear carry register, set slice index 0, enter ADD.
REQ-012 ADD SHALL process slice k (bits 8k+7:8k) per cycle: sum slice = a_k + b_k + carry_reg, result slice registered, carry_reg updated; slice 0 SHALL use carry-in 0.
REQ-013 After slice N_SLICES-1 the FSM SHALL enter RESP; rsp_valid rises exactly N_SLICES cycles after the accept edge.
REQ-014 rsp_sum SHALL equal (a+b) mod 2^W; rsp_carry SHALL equal carry out of top slice.
REQ-015 RESP: rsp_valid=1; rsp_sum, rsp_carry, rsp_id SHALL hold stable while rsp_ready=0.
REQ-016 On rsp_valid & rsp_ready the FSM SHALL return to IDLE next edge; no new accept in that same cycle (throughput one op per N_SLICES+2 cycles minimum).
REQ-017 Requester dropping valid before being granted SHALL have no effect; pending ungranted requests wait indefinitely.
REQ-018 Operand inputs SHALL be sampled only on the accept edge; later changes SHALL not affect the result.

Reset
REQ-019 rst asserted SHALL immediately force IDLE, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, carry_reg=0, slice index 0, RR pointer favouring req0.
REQ-020 Reset mid-ADD or mid-RESP SHALL abort the transaction; no response for it is ever produced.

Structure
REQ-021 Shared package add_sched_pkg SHALL hold SLICE_W=8 and the FSM state enum.
REQ-022 The per-slice adder SHALL be sub-module adder_slice8 (8-bit ripple chain of full adders with carry_in and carry_out); one instance only.

Verification
REQ-023 Bench SHALL cover: req0 a=100, b=45 -> rsp_sum=145, rsp_carry=0, rsp_id=0, rsp_valid 2 cycles after accept.
REQ-024 Bench SHALL cover: req1 a=0x00FF, b=0x0001 -> rsp_sum=0x0100, carry propagates slice0->slice1, rsp_carry=0, rsp_id=1.
REQ-025 Bench SHALL cover: req0 a=0xFFFF, b=0x0001 -> rsp_sum=0x0000, rsp_carry=1.
REQ-026 Bench SHALL cover: both valid continuously for 4 ops with rsp_ready=1 -> rsp_id sequence 0,1,0,1.
REQ-027 Bench SHALL cover: rsp_ready=0 for 5 cycles in RESP -> outputs stable, req0_ready=req1_ready=0, single completion on release.
REQ-028 Bench SHALL cover: rst pulse during ADD -> rsp_valid=0 immediately, no response emitted, next simultaneous request granted to req0.
